// File: rtl/gate_pkg.sv
// Shared state encoding and default parameter values for the receive-gate window logic.
package gate_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_WAIT = 2'd1,
    GS_OPEN = 2'd2
  } gate_state_t;

  localparam int GATE_DEF_WIDTH  = 8;
  localparam int GATE_DEF_DELAY  = 3;
  localparam int GATE_DEF_WINDOW = 1;

endpackage

// File: rtl/gate_win_timer.sv
// Edge detect, delay/window counter and sequencing FSM for gate_window.
// Optional restart-on-rise while busy is enabled by defining GATE_WIN_RETRIG_EN.
module gate_win_timer
  import gate_pkg::*;
#(
  parameter int DELAY  = GATE_DEF_DELAY,
  parameter int WINDOW = GATE_DEF_WINDOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic priem,
  output logic win_open,
  output logic win_end,
  output logic start,
  output logic busy
);

  localparam int CNT_W = $clog2(DELAY + WINDOW + 1);
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] WIN_LD = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  gate_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             priem_d_q;
  logic             win_open_q, win_open_d;
  logic             rise_s;
  logic             start_s;

  // Next-state, counter and window-flag computation
  always_comb begin
    rise_s     = priem & ~priem_d_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_open_d = win_open_q;
    start_s    = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (rise_s) begin
          state_d = GS_WAIT;
          cnt_d   = DLY_LD;
          start_s = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      GS_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d    = GS_OPEN;
          win_open_d = 1'b1;
          cnt_d      = WIN_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GS_OPEN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d    = GS_IDLE;
          win_open_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = GS_IDLE;
        cnt_d      = CNT_ZERO;
        win_open_d = 1'b0;
      end
    endcase
`ifdef GATE_WIN_RETRIG_EN
    // A fresh strobe while busy overrides whatever the case above decided
    if (rise_s && (state_q != GS_IDLE)) begin
      state_d    = GS_WAIT;
      cnt_d      = DLY_LD;
      win_open_d = 1'b0;
      start_s    = 1'b1;
    end else begin
      start_s = start_s;
    end
`endif
  end

  // State, counter, window flag and priem history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= GS_IDLE;
      cnt_q      <= CNT_ZERO;
      priem_d_q  <= 1'b0;
      win_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      priem_d_q  <= priem;
      win_open_q <= win_open_d;
    end
  end

  assign win_open = win_open_q;
  assign win_end  = (state_q == GS_OPEN) && (cnt_q == CNT_ZERO);
  assign start    = start_s;
  assign busy     = (state_q != GS_IDLE);

endmodule

// File: rtl/gate_window.sv
// Receive gate: after a priem rise and a programmable delay, captures the first qualified word
// inside the sampling window. Build option GATE_WIN_RETRIG_EN lets a rise while busy restart.
module gate_window
  import gate_pkg::*;
#(
  parameter int WIDTH  = GATE_DEF_WIDTH,
  parameter int DELAY  = GATE_DEF_DELAY,
  parameter int WINDOW = GATE_DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             priem,
  input  logic             sig,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             right_cursor,
  output logic             win_open,
  output logic             busy,
  output logic             miss
);

  logic             win_open_s, win_end_s, start_s, busy_s;
  logic             cap_s;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             miss_q, miss_d;

  gate_win_timer #(
    .DELAY  (DELAY),
    .WINDOW (WINDOW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .priem    (priem),
    .win_open (win_open_s),
    .win_end  (win_end_s),
    .start    (start_s),
    .busy     (busy_s)
  );

  // Capture, hit tracking and miss detection; a capture on the closing edge suppresses miss
  always_comb begin
    cap_s       = win_open_s & sig & ~hit_q;
    hit_d       = hit_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    miss_d      = 1'b0;
    if (cap_s) begin
      res_d       = inp;
      res_valid_d = 1'b1;
      hit_d       = 1'b1;
    end else begin
      res_d = res_q;
    end
    if (start_s) begin
      hit_d = 1'b0;
    end else begin
      hit_d = hit_d;
    end
    if (win_end_s && !hit_q && !cap_s && !start_s) begin
      miss_d = 1'b1;
    end else begin
      miss_d = 1'b0;
    end
  end

  // Output and hit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      res_valid_q <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      miss_q      <= miss_d;
    end
  end

  assign res          = res_q;
  assign res_valid    = res_valid_q;
  assign miss         = miss_q;
  assign win_open     = win_open_s;
  assign busy         = busy_s;
  assign right_cursor = win_open_s & sig;

endmodule

// File: tb/tb_gate_window.sv
// Directed self-checking bench for gate_window: default, DELAY=2/WINDOW=4 and WINDOW=3 builds.
`timescale 1ns/1ps
module tb_gate_window;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       p0 = 1'b0, s0 = 1'b0;
  logic [7:0] i0 = 8'h00;
  logic [7:0] r0;
  logic       v0, rc0, w0, b0, m0;

  logic       p1 = 1'b0, s1 = 1'b0;
  logic [7:0] i1 = 8'h00;
  logic [7:0] r1;
  logic       v1, rc1, w1, b1, m1;

  logic       p2 = 1'b0, s2 = 1'b0;
  logic [7:0] i2 = 8'h00;
  logic [7:0] r2;
  logic       v2, rc2, w2, b2, m2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_window u_def (
    .clk(clk), .rst_n(rst_n), .priem(p0), .sig(s0), .inp(i0),
    .res(r0), .res_valid(v0), .right_cursor(rc0), .win_open(w0), .busy(b0), .miss(m0)
  );

  gate_window #(.WIDTH(8), .DELAY(2), .WINDOW(4)) u_d2w4 (
    .clk(clk), .rst_n(rst_n), .priem(p1), .sig(s1), .inp(i1),
    .res(r1), .res_valid(v1), .right_cursor(rc1), .win_open(w1), .busy(b1), .miss(m1)
  );

  gate_window #(.WIDTH(8), .DELAY(3), .WINDOW(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .priem(p2), .sig(s2), .inp(i2),
    .res(r2), .res_valid(v2), .right_cursor(rc2), .win_open(w2), .busy(b2), .miss(m2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_res", r0, 8'h00);
    chk("rst_valid", v0, 1'b0);
    chk("rst_win", w0, 1'b0);
    chk("rst_busy", b0, 1'b0);
    chk("rst_miss", m0, 1'b0);
    chk("rst_busy_w3", b2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Default build, capture in the single window cycle
    i0 = 8'hA5; p0 = 1'b1;
    cyc(1);
    chk("t1_busy_n", b0, 1'b1);
    chk("t1_win_n", w0, 1'b0);
    p0 = 1'b0;
    cyc(2);
    chk("t1_win_n2", w0, 1'b0);
    cyc(1);
    chk("t1_win_n3", w0, 1'b1);
    s0 = 1'b1;
    #1;
    chk("t1_cursor", rc0, 1'b1);
    cyc(1);
    s0 = 1'b0;
    chk("t1_res", r0, 8'hA5);
    chk("t1_valid", v0, 1'b1);
    chk("t1_win_n4", w0, 1'b0);
    chk("t1_miss", m0, 1'b0);
    chk("t1_busy_n4", b0, 1'b0);
    cyc(1);
    chk("t1_valid_pulse", v0, 1'b0);

    // Window with no qualified word raises miss
    i0 = 8'h5A; p0 = 1'b1;
    cyc(1);
    p0 = 1'b0;
    cyc(3);
    chk("t3_win_n3", w0, 1'b1);
    cyc(1);
    chk("t3_miss", m0, 1'b1);
    chk("t3_busy", b0, 1'b0);
    chk("t3_res_kept", r0, 8'hA5);
    chk("t3_valid", v0, 1'b0);
    cyc(1);
    chk("t3_miss_pulse", m0, 1'b0);

    // priem held high for 10 cycles gives a single window
    p0 = 1'b1;
    cyc(1);
    cyc(3);
    chk("t4_win_n3", w0, 1'b1);
    cyc(1);
    chk("t4_win_n4", w0, 1'b0);
    cyc(6);
    chk("t4_no_second", b0, 1'b0);
    p0 = 1'b0;
    cyc(2);

    // Second rise two cycles into a sequence
    p0 = 1'b1;
    cyc(1);
    p0 = 1'b0;
    cyc(1);
    p0 = 1'b1;
    cyc(1);
    p0 = 1'b0;
`ifdef GATE_WIN_RETRIG_EN
    cyc(1);
    chk("t4r_win_n3", w0, 1'b0);
    cyc(1);
    chk("t4r_win_n4", w0, 1'b0);
    chk("t4r_miss_n4", m0, 1'b0);
    cyc(1);
    chk("t4r_win_n5", w0, 1'b1);
    i0 = 8'h77; s0 = 1'b1;
    cyc(1);
    s0 = 1'b0;
    chk("t4r_res", r0, 8'h77);
    chk("t4r_miss_n6", m0, 1'b0);
`else
    cyc(1);
    chk("t4b_win_n3", w0, 1'b1);
    cyc(1);
    chk("t4b_win_n4", w0, 1'b0);
    chk("t4b_miss_n4", m0, 1'b1);
    chk("t4b_busy_n4", b0, 1'b0);
    cyc(1);
    chk("t4b_win_n5", w0, 1'b0);
    chk("t4b_miss_n5", m0, 1'b0);
`endif
    cyc(2);

    // Async reset mid-sequence
    p0 = 1'b1;
    cyc(1);
    p0 = 1'b0;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", b0, 1'b0);
    chk("t5_win", w0, 1'b0);
    chk("t5_res", r0, 8'h00);
    chk("t5_valid", v0, 1'b0);
    chk("t5_miss", m0, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t5_post_win", w0, 1'b0);
      chk("t5_post_miss", m0, 1'b0);
    end

    // DELAY=2, WINDOW=4: first qualified word wins
    p1 = 1'b1;
    cyc(1);
    p1 = 1'b0;
    cyc(1);
    chk("t2_win_n1", w1, 1'b0);
    cyc(1);
    chk("t2_win_n2", w1, 1'b1);
    cyc(1);
    s1 = 1'b1; i1 = 8'h11;
    cyc(1);
    chk("t2_res_first", r1, 8'h11);
    chk("t2_valid_first", v1, 1'b1);
    i1 = 8'h22;
    cyc(1);
    s1 = 1'b0;
    chk("t2_res_kept", r1, 8'h11);
    chk("t2_valid_once", v1, 1'b0);
    chk("t2_win_n5", w1, 1'b1);
    cyc(1);
    chk("t2_win_n6", w1, 1'b0);
    chk("t2_miss", m1, 1'b0);
    chk("t2_busy", b1, 1'b0);

    // WINDOW=3: capture in the last window cycle
    p2 = 1'b1;
    cyc(1);
    p2 = 1'b0;
    cyc(3);
    chk("t6_win_n3", w2, 1'b1);
    cyc(2);
    chk("t6_win_n5", w2, 1'b1);
    s2 = 1'b1; i2 = 8'h3C;
    cyc(1);
    s2 = 1'b0;
    chk("t6_res", r2, 8'h3C);
    chk("t6_valid", v2, 1'b1);
    chk("t6_win_n6", w2, 1'b0);
    chk("t6_miss", m2, 1'b0);
    chk("t6_busy", b2, 1'b0);
    cyc(1);
    chk("t6_miss_after", m2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_window.md
Name: gate_window

Overview:
- Parametrised successor of the receive-gate / cursor logic.
- A rising edge on priem arms a programmable delay, then a sampling window of programmable length opens.
- The first data word presented with sig high inside the window is captured and flagged valid; a window that closes with no hit raises miss.
- Sits between the serial front-end strobe (priem) and the downstream byte consumer; replaces fixed delay taps with one counter-based FSM.

Parameters:
- WIDTH, 8, data width of inp/res.
- DELAY, 3, cycles from priem rising edge to window open; legal range >=1.
- WINDOW, 1, window length in cycles; legal range >=1.
- CNT_W, $clog2(DELAY+WINDOW+1), internal counter width (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- priem  in  1  receive strobe; its rising edge starts a sequence.
- sig  in  1  data-qualify strobe.
- inp  in  WIDTH  data word.
- res  out  WIDTH  captured word, registered, held until next capture.
- res_valid  out  1  one-cycle pulse, res updated.
- right_cursor  out  1  combinational: win_open & sig.
- win_open  out  1  registered window indicator.
- busy  out  1  high in WAIT or OPEN.
- miss  out  1  one-cycle pulse, window ended without capture.

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, priem_d 0, res 0, res_valid 0, win_open 0, miss 0, hit flag 0.
- Edge detect: rise = priem & ~priem_d, with priem_d registered every cycle. A priem held high produces one rise only.
- FSM states IDLE, WAIT, OPEN; busy = (state != IDLE).
- IDLE: on rise sampled at edge N, go to WAIT and clear the hit flag.
- WAIT: win_open goes high at edge N+DELAY, and state becomes OPEN. With DELAY=1, WAIT lasts one cycle.
- OPEN: win_open stays high for exactly WINDOW cycles and drops at edge N+DELAY+WINDOW; state returns to IDLE.
- Defaults DELAY=3, WINDOW=1 reproduce the legacy cursor pulse: one cycle, from 3 to 4 cycles after priem.
- Capture: in any cycle with win_open & sig & !hit, the next edge loads res<=inp, pulses res_valid, and sets hit. Later sig in the same window is ignored. The window is never shortened by a capture.
- Miss: at the edge where win_open falls, if hit=0 (including no capture on that edge), miss pulses for one cycle.
- Capture and miss on the same edge: capture wins and miss stays 0.
- Retrigger: a rise while busy is ignored (see optional feature).
- A rise on the same edge the FSM returns to IDLE is ignored. The next sequence needs a rise sampled while in IDLE.
- priem is assumed synchronous to clk; no internal synchroniser.
- Async reset mid-sequence aborts immediately with no miss pulse. After release, FSM waits for a fresh rise; a priem already high at release counts as a rise because priem_d is 0.

Optional Feature:
- GATE_WIN_RETRIG_EN defined: a rise while in WAIT or OPEN restarts the sequence from that edge. This closes any open window without a miss pulse, clears hit, and re-enters WAIT.
- GATE_WIN_RETRIG_EN undefined: rises while busy are ignored, as stated in Behaviour.

Decomposition:
- Package gate_pkg:
  - typedef enum logic [1:0] gate_state_t {GS_IDLE, GS_WAIT, GS_OPEN};
  - default constants GATE_DEF_WIDTH=8, GATE_DEF_DELAY=3, GATE_DEF_WINDOW=1.
- One sub-module gate_win_timer holds edge detect, counter and FSM. It outputs win_open, win_end (last-cycle strobe) and busy. gate_window adds the capture, hit and miss logic around it.

Test Plan:
- Defaults, inp=8'hA5, priem rise at edge 10, sig high only in cycle 13 -> win_open high only in cycle 13; right_cursor high in 13; res=8'hA5 and res_valid pulse at edge 14; miss 0.
- DELAY=2, WINDOW=4, priem rise at edge 5, sig high in cycles 8 and 9 with inp 8'h11 then 8'h22 -> win_open cycles 7-10; res=8'h11 only; one res_valid at edge 9.
- Defaults, priem rise, sig never high -> miss single pulse at edge N+4; res keeps its old value; busy low from edge N+4.
- Defaults, priem held high for 10 cycles, then a second rise at N+2 -> exactly one window (cycle N+3); second rise ignored without the macro. With GATE_WIN_RETRIG_EN, the window moves to cycle N+5 and no miss is generated.
- rst_n low in cycle N+2 of a sequence, released at N+5 -> all outputs 0 immediately; no window, no miss until a new priem rise.
- WINDOW=3, sig high only in the last window cycle -> capture and res_valid at the closing edge; miss stays 0.
